gate_vector_checker: RTL and testbench
======================================

// Module: gate_vector_checker
// PURPOSE
//  Synthesizable self-checking stimulus stage for 2-input logic gates (and, or, nand, xor, ...).
//  Sits directly upstream and downstream of the gate under test (GUT).
//  Drives all four {a,b} input vectors onto the GUT, waits a settle window, then samples the
//  GUT output and compares it with a parameterised truth table.
//  Reports an error count, the first failing vector and a pass/done status for board-level
//  or simulation bring-up.
// PARAMETERS
//  TRUTH   4'b1000  expected GUT output; bit index = {a,b} (4'b1000 = and, 4'b1110 = or)
//  SETTLE  1        wait cycles between driving a vector and sampling it; legal range 1..15
// PORTS
//  clk         in   1  single clock; all state updates on rising edge
//  reset       in   1  synchronous, active-high reset
//  start       in   1  request a run; sampled only in IDLE or DONE
//  gut_out     in   1  output of the gate under test
//  a           out  1  GUT input a (registered)
//  b           out  1  GUT input b (registered)
//  busy        out  1  high while a run is in progress (DRIVE/SETTLE/CHECK)
//  done        out  1  high in DONE; held until next accepted start or reset
//  pass        out  1  valid while done=1; 1 when err_cnt==0
//  err_cnt     out  3  number of mismatching vectors in the current/last run (0..4)
//  fail_valid  out  1  a mismatch has been captured in this run
//  fail_vec    out  2  {a,b} of the first mismatching vector; meaningful only if fail_valid=1
// BEHAVIOUR
//  Reset:
//   - reset=1 at an edge forces state=IDLE, a=b=0, vec=0, err_cnt=0, fail_valid=0,
//     fail_vec=0, busy=done=pass=0.
//   - Reset has priority over every other input, including mid-run; no partial result is kept.
//  FSM states: IDLE -> DRIVE -> SETTLE -> CHECK -> (DRIVE | DONE).
//   - IDLE: if start=1, go to DRIVE; vec=0, a=b=0, err_cnt=0, fail_valid=0.
//   - DRIVE: one cycle; {a,b}=vec is held on outputs; next SETTLE with wait counter=SETTLE-1.
//   - SETTLE: while counter!=0, decrement; at counter==0 go to CHECK.
//     SETTLE therefore lasts exactly SETTLE cycles.
//   - CHECK: one cycle; at its ending edge compare gut_out with TRUTH[vec].
//     On mismatch: err_cnt+=1 and, if fail_valid=0, set fail_valid=1 and fail_vec=vec.
//     If vec==3, go to DONE; else vec+=1, {a,b}=vec+1, go to DRIVE.
//   - DONE: done=1, busy=0, pass=(err_cnt==0); a,b hold 2'b11.
//     If start=1, restart exactly as from IDLE (counts cleared in the same edge).
//  Timing:
//   - Latency: with start accepted at edge E0, done rises after edge E0 + 4*(2+SETTLE)
//     (E12 for SETTLE=1).
//   - Each vector is held for 2+SETTLE cycles.
//   - busy=1 from after E0 through the last CHECK cycle; busy and done are never both 1.
//  Boundary conditions:
//   - start while busy=1 is ignored and does not queue.
//   - start held high continuously in DONE restarts every time DONE is entered
//     (back-to-back runs, one DONE cycle each).
//   - err_cnt saturates naturally at 4 (3 bits); no wrap.
//   - vec wraps only via restart; it never increments past 3.
//   - gut_out is sampled only in CHECK; glitches in DRIVE/SETTLE have no effect.
// TESTING
//  T1 GUT=and, TRUTH=4'b1000, SETTLE=1, pulse start
//     -> a,b step 00,01,10,11; done=1 after E12; pass=1, err_cnt=0, fail_valid=0.
//  T2 GUT stuck-at-0, TRUTH=4'b1000
//     -> err_cnt=1, fail_valid=1, fail_vec=2'b11, pass=0.
//  T3 GUT=nand, TRUTH=4'b1000
//     -> err_cnt=4, fail_vec=2'b00 (first mismatch kept), pass=0.
//  T4 reset=1 for one cycle during SETTLE of vector 2
//     -> next cycle IDLE, a=b=0, busy=0, err_cnt=0; new start runs a full 12-cycle pass.
//  T5 start pulsed again during CHECK of vector 1
//     -> ignored, done still after E12.
//     Then start in DONE -> err_cnt/fail_valid cleared, second run completes identically.
//  T6 GUT=or, TRUTH=4'b1110, SETTLE=3
//     -> done after E0+20, pass=1; each vector held 5 cycles.

Source files
------------

// File: rtl/gate_vector_checker.sv
`default_nettype none
// ============================================================================
// Module  : gate_vector_checker
// Purpose : Drives all four {a,b} vectors onto a 2-input gate, samples its
//           output after a settle window and checks it against TRUTH.
// Rev     : 1.0  initial release
// ============================================================================
module gate_vector_checker #(
  parameter logic [3:0] TRUTH  = 4'b1000,
  parameter int         SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       gut_out,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic       fail_valid,
  output logic [1:0] fail_vec
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] C_SETTLE_INIT = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [1:0] ab_q, ab_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] err_cnt_q, err_cnt_d;
  logic       fail_valid_q, fail_valid_d;
  logic [1:0] fail_vec_q, fail_vec_d;
  logic       w_mismatch;

  assign w_mismatch = (gut_out != TRUTH[vec_q]);

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    ab_d         = ab_q;
    cnt_d        = cnt_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // A restart from DONE clears the previous result in the same edge.
        if (start) begin
          state_d      = S_DRIVE;
          vec_d        = 2'd0;
          ab_d         = 2'd0;
          err_cnt_d    = 3'd0;
          fail_valid_d = 1'b0;
          fail_vec_d   = 2'd0;
        end
      end
      S_DRIVE: begin
        state_d = S_SETTLE;
        cnt_d   = C_SETTLE_INIT;
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_CHECK: begin
        if (w_mismatch) begin
          err_cnt_d = err_cnt_q + 3'd1;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
          end
        end
        if (vec_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          ab_d    = vec_q + 2'd1;
          state_d = S_DRIVE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      vec_q        <= 2'd0;
      ab_q         <= 2'd0;
      cnt_q        <= 4'd0;
      err_cnt_q    <= 3'd0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      ab_q         <= ab_d;
      cnt_q        <= cnt_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign a          = ab_q[1];
  assign b          = ab_q[0];
  assign busy       = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign pass       = done && (err_cnt_q == 3'd0);
  assign err_cnt    = err_cnt_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_vector_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_gate_vector_checker
// Purpose : Directed and randomized runs of gate_vector_checker against a
//           truth-table reference model (two parameterisations).
// Rev     : 1.0  initial release
// ============================================================================
module tb_gate_vector_checker;

  logic clk = 1'b0;
  logic reset;
  logic gut_out;
  logic start0, start1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   sel     = 0;

  logic       a0, b0, busy0, done0, pass0, fv0;
  logic [2:0] err0;
  logic [1:0] fvec0;
  logic       a1, b1, busy1, done1, pass1, fv1;
  logic [2:0] err1;
  logic [1:0] fvec1;

  always #5 clk = ~clk;

  gate_vector_checker #(.TRUTH(4'b1000), .SETTLE(1)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .gut_out(gut_out),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_valid(fv0), .fail_vec(fvec0)
  );

  gate_vector_checker #(.TRUTH(4'b1110), .SETTLE(3)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .gut_out(gut_out),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_valid(fv1), .fail_vec(fvec1)
  );

  // Observed outputs of whichever instance is currently under test.
  logic [1:0] o_ab, o_fvec;
  logic       o_busy, o_done, o_pass, o_fv;
  logic [2:0] o_err;
  always_comb begin
    if (sel == 0) begin
      o_ab = {a0, b0}; o_busy = busy0; o_done = done0; o_pass = pass0;
      o_err = err0; o_fv = fv0; o_fvec = fvec0;
    end else begin
      o_ab = {a1, b1}; o_busy = busy1; o_done = done1; o_pass = pass1;
      o_err = err1; o_fv = fv1; o_fvec = fvec1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start0 = v; else start1 = v;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_pass"}, 32'(o_pass), 0);
    chk({tag, "_ab"},   32'(o_ab), 0);
    chk({tag, "_err"},  32'(o_err), 0);
    chk({tag, "_fv"},   32'(o_fv), 0);
  endtask

  // One complete run, called at a negedge; returns at the negedge where DONE
  // is first visible with start deasserted (so the next call is back-to-back).
  // abort_k >= 0 asserts reset in that cycle instead of finishing the run.
  task automatic run(input int s_sel, input logic [3:0] gut_tt, input logic [3:0] truth,
                     input int settle, input bit noisy, input int abort_k);
    logic [3:0] diff;
    int exp_err, exp_fvec, per, v, ph;
    sel = s_sel;
    per = settle + 2;
    diff = gut_tt ^ truth;
    exp_err = $countones(diff);
    exp_fvec = 0;
    for (int i = 3; i >= 0; i--) if (diff[i]) exp_fvec = i;
    set_start(1'b1);
    gut_out = 1'($urandom);
    @(negedge clk);
    for (int k = 0; k < 4 * per; k++) begin
      v  = k / per;
      ph = k % per;
      if (k == abort_k) begin
        reset = 1'b1;
        set_start(1'b0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      chk("run_busy", 32'(o_busy), 1);
      chk("run_done", 32'(o_done), 0);
      chk("run_ab", 32'(o_ab), 32'(v));
      if (k == 0) begin
        chk("run_err_clr", 32'(o_err), 0);
        chk("run_fv_clr", 32'(o_fv), 0);
      end
      // Only the value present during the last cycle of the window matters.
      if (ph == per - 1 || !noisy) gut_out = gut_tt[v];
      else gut_out = 1'($urandom);
      set_start(noisy ? 1'($urandom) : 1'b0);
      @(negedge clk);
    end
    set_start(1'b0);
    chk("end_done", 32'(o_done), 1);
    chk("end_busy", 32'(o_busy), 0);
    chk("end_ab", 32'(o_ab), 3);
    chk("end_err", 32'(o_err), 32'(exp_err));
    chk("end_pass", 32'(o_pass), 32'(exp_err == 0));
    chk("end_fv", 32'(o_fv), 32'(exp_err != 0));
    if (exp_err != 0) chk("end_fvec", 32'(o_fvec), 32'(exp_fvec));
  endtask

  initial begin
    logic [3:0] tt;
    int rsel;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; gut_out = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sel = 0; chk_idle("rst0");
    sel = 1; chk_idle("rst1");
    @(negedge clk);
    sel = 0; chk_idle("idle0");

    // and gate, stuck-at-0, nand on the AND checker
    run(0, 4'b1000, 4'b1000, 1, 1'b0, -1);
    @(negedge clk);
    run(0, 4'b0000, 4'b1000, 1, 1'b0, -1);
    // DONE holds with start low
    repeat (3) @(negedge clk);
    chk("hold_done", 32'(o_done), 1);
    chk("hold_err", 32'(o_err), 1);
    chk("hold_fvec", 32'(o_fvec), 3);
    run(0, 4'b0111, 4'b1000, 1, 1'b0, -1);

    // reset during SETTLE of vector 2, then a clean full run
    @(negedge clk);
    run(0, 4'b0111, 4'b1000, 1, 1'b0, 2 * 3 + 1);
    chk_idle("abort");
    @(negedge clk);
    chk_idle("abort_idle");
    run(0, 4'b1000, 4'b1000, 1, 1'b0, -1);

    // noisy start/gut_out during the run, then back-to-back restarts
    run(0, 4'b1000, 4'b1000, 1, 1'b1, -1);
    run(0, 4'b0001, 4'b1000, 1, 1'b1, -1);
    run(0, 4'b1000, 4'b1000, 1, 1'b1, -1);

    // or gate on the SETTLE=3 checker
    run(1, 4'b1110, 4'b1110, 3, 1'b0, -1);
    run(1, 4'b1110, 4'b1110, 3, 1'b1, -1);

    for (int r = 0; r < 12; r++) begin
      tt = 4'($urandom);
      rsel = int'($urandom_range(0, 1));
      if (rsel == 0) run(0, tt, 4'b1000, 1, 1'($urandom), -1);
      else           run(1, tt, 4'b1110, 3, 1'($urandom), -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
